// File: rtl/memory_responder.sv
// memory_responder: byte-wide ROM/RAM/IO responder with per-region wait states and a ROM load port
module memory_responder #(
  parameter int unsigned ROM_WAIT = 0,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [7:0]  to_memory,
  output logic [7:0]  from_memory,
  output logic        ready,
  output logic        err,
  output logic        busy,
  input  logic [31:0] port_in,
  output logic [31:0] port_out,
  input  logic        load_en,
  input  logic [6:0]  load_addr,
  input  logic [7:0]  load_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic [31:0] sync1, sync2;
  logic [7:0]  rom [128];
  logic [7:0]  ram [96];
  logic        accept;
  logic        commit;
  logic        in_rom;
  logic        in_ram;
  logic        in_po;
  logic        in_pi;
  logic [4:0]  lane;
  logic [3:0]  req_wait;
  logic [7:0]  rd_data;

  assign accept   = state == IDLE && req;
  assign commit   = state == WAIT && cnt == 4'd0;
  assign in_rom   = !addr_q[7];
  assign in_ram   = addr_q[7] && addr_q < 8'hE0;
  assign in_po    = addr_q[7:2] == 6'b111000;
  assign in_pi    = addr_q[7:2] == 6'b111100;
  assign lane     = {addr_q[1:0], 3'b000};
  assign req_wait = !address[7] ? 4'(ROM_WAIT) : address < 8'hE0 ? 4'(RAM_WAIT) : 4'(IO_WAIT);

  assign ready = state == RESP;
  assign busy  = state != IDLE;
  assign err   = ready && we_q && in_rom;

  // Next state: IDLE waits for req, WAIT counts down, RESP lasts one cycle
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (req ? WAIT : IDLE) :
                state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  end

  // Read mux over the latched address; RAM index is address-0x80, i.e. its low 7 bits
  always_comb begin
    rd_data = 8'h00;
    rd_data = in_rom ? rom[addr_q[6:0]] :
              in_ram ? ram[addr_q[6:0]] :
              in_po  ? port_out[lane +: 8] :
              in_pi  ? sync2[lane +: 8] : 8'h00;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end

  // Request latch and wait-state counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else if (accept) begin
      cnt    <= req_wait;
      we_q   <= we;
      addr_q <= address;
      data_q <= to_memory;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Read data and output ports are committed on the WAIT->RESP edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      from_memory <= 8'h00;
      port_out    <= 32'h0;
    end else begin
      if (commit && !we_q) from_memory <= rd_data;
      if (commit && we_q && in_po) port_out[lane +: 8] <= data_q;
    end
  end

  // Two-flop synchronizer for the asynchronous input ports
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 32'h0;
      sync2 <= 32'h0;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
    end
  end

  // Memory arrays keep contents across reset; a reset forces IDLE so no write can commit
  always_ff @(posedge clk) begin
    if (commit && we_q && in_ram) ram[addr_q[6:0]] <= data_q;
    if (state == IDLE && load_en && !req) rom[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench with a behavioural memory-map model
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  to_memory = 8'h00;
  logic [7:0]  from_memory;
  logic        ready;
  logic        err;
  logic        busy;
  logic [31:0] port_in = 32'h0;
  logic [31:0] port_out;
  logic        load_en = 1'b0;
  logic [6:0]  load_addr = 7'h00;
  logic [7:0]  load_data = 8'h00;

  memory_responder #(.ROM_WAIT(0), .RAM_WAIT(1), .IO_WAIT(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address),
    .to_memory(to_memory), .from_memory(from_memory), .ready(ready),
    .err(err), .busy(busy), .port_in(port_in), .port_out(port_out),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic e;} exp_t;
  exp_t sbq[$];

  logic [7:0] m_rom [128];
  logic [7:0] m_ram [96];
  logic [7:0] m_po [4];
  logic [7:0] m_last = 8'h00;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    if (a < 128) return m_rom[a];
    if (a < 224) return m_ram[a - 128];
    if (a < 228) return m_po[a - 224];
    if (a >= 240 && a < 244) return port_in[(a - 240) * 8 +: 8];
    return 8'h00;
  endfunction

  function automatic int m_wait(input int a);
    return a < 128 ? 0 : a < 224 ? 1 : 2;
  endfunction

  // Monitor: every ready pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (reset && ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending response at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("rdata", {24'h0, from_memory}, {24'h0, e.d});
        chk("err", {31'h0, err}, {31'h0, e.e});
      end
    end
  end

  task automatic load(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
    m_rom[a] = d;
  endtask

  // coll: 0 plain, 1 req/load pulsed while busy, 2 load_en together with req in IDLE
  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d, input int coll);
    int n;
    exp_t e;
    @(negedge clk);
    req = 1'b1;
    we = w;
    address = a;
    to_memory = d;
    if (coll == 2) begin
      load_en = 1'b1;
      load_addr = a[6:0];
      load_data = ~m_rom[a[6:0]];
    end
    if (!w) m_last = m_read(int'(a));
    else if (a >= 8'h80 && a < 8'hE0) m_ram[a - 8'h80] = d;
    else if (a >= 8'hE0 && a < 8'hE4) m_po[a - 8'hE0] = d;
    e.d = m_last;
    e.e = w && a < 8'h80;
    sbq.push_back(e);
    @(posedge clk);
    #1 req = 1'b0;
    load_en = 1'b0;
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    n = 0;
    while (!ready && n < 40) begin
      if (coll == 1 && n == 0) begin
        req = 1'b1;
        we = 1'b1;
        address = ~a;
        load_en = 1'b1;
        load_addr = 7'h21;
        load_data = ~m_rom[7'h21];
      end
      @(posedge clk);
      #1 req = 1'b0;
      load_en = 1'b0;
      n++;
    end
    chk("latency", n, m_wait(int'(a)) + 1);
    @(posedge clk);
    #1 chk("port_out", port_out, {m_po[3], m_po[2], m_po[1], m_po[0]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         r;
    for (int i = 0; i < 4; i++) m_po[i] = 8'h00;
    #1;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", {24'h0, from_memory}, 32'h0);
    chk("rst_port_out", port_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 128; i++) load(7'(i), 8'($urandom));
    load(7'h05, 8'h3C);
    access(1'b0, 8'h05, 8'h00, 0);
    for (int i = 0; i < 96; i++) access(1'b1, 8'(8'h80 + i), 8'($urandom), 0);
    access(1'b1, 8'h90, 8'hA5, 0);
    access(1'b0, 8'h90, 8'h00, 0);
    access(1'b1, 8'h10, 8'h77, 0);
    access(1'b0, 8'h10, 8'h00, 0);
    access(1'b1, 8'hE2, 8'h5A, 0);
    chk("port2", {24'h0, port_out[23:16]}, 32'h5A);
    @(negedge clk);
    port_in[7:0] = 8'hC3;
    repeat (2) @(posedge clk);
    access(1'b0, 8'hF0, 8'h00, 0);
    access(1'b0, 8'hE8, 8'h00, 0);
    access(1'b0, 8'h90, 8'h00, 1);
    access(1'b0, 8'h21, 8'h00, 0);
    access(1'b0, 8'h20, 8'h00, 2);
    access(1'b0, 8'h20, 8'h00, 0);
    @(negedge clk);
    req = 1'b1;
    we = 1'b1;
    address = 8'h95;
    to_memory = ~m_ram[8'h15];
    @(posedge clk);
    #1 req = 1'b0;
    chk("busy_before_abort", {31'h0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_po[i] = 8'h00;
    m_last = 8'h00;
    #1;
    chk("abort_ready", {31'h0, ready}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_err", {31'h0, err}, 32'h0);
    chk("abort_rdata", {24'h0, from_memory}, 32'h0);
    chk("abort_port_out", port_out, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ready", {31'h0, ready}, 32'h0);
    end
    reset = 1'b1;
    access(1'b0, 8'h95, 8'h00, 0);
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r == 0) load(7'($urandom), 8'($urandom));
      else if (r == 1) begin
        @(negedge clk);
        port_in = $urandom;
        repeat (3) @(posedge clk);
      end else begin
        w = 1'($urandom);
        a = 8'($urandom);
        d = 8'($urandom);
        access(w, a, d, 0);
      end
    end
    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
